gather_unpacker: RTL and testbench

- Network-side receive stage for gather traffic. It sits between the router local output port and the PE input.
- It consumes HEAD/BODY/TAIL packets produced by the gather packer, latches the 10-bit stream_id from each HEAD and strips HEAD/TAIL.
- BODY payloads are buffered in a small FIFO and presented to the PE tagged with stream_id and a last-of-packet marker.
- Malformed packets (stray, short, long or nested) are detected and reported on a one-cycle error strobe.

---
 rtl/gather_unpacker_pkg.sv | 31 +++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/gather_unpacker.sv | 139 +++++++++++++
 tb/tb_gather_unpacker.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/gather_unpacker_pkg.sv
// Shared types and constants for the gather receive path.
package gather_unpacker_pkg;

  localparam int unsigned DW          = 34;
  localparam int unsigned PKT_LEN     = 8;
  localparam int unsigned PKT_LEN_LOG = 3;
  localparam int unsigned NB          = PKT_LEN - 2;
  localparam int unsigned SID_W       = 10;

  // Flit type field, carried in data[DW-1:DW-2]
  localparam logic [1:0] HEAD = 2'd0;
  localparam logic [1:0] BODY = 2'd1;
  localparam logic [1:0] TAIL = 2'd2;

  typedef enum logic [1:0] {
    ERR_STRAY  = 2'd0,
    ERR_SHORT  = 2'd1,
    ERR_LONG   = 2'd2,
    ERR_NESTED = 2'd3
  } err_code_e;

  typedef enum logic {
    WAIT_HEAD = 1'b0,
    IN_PKT    = 1'b1
  } state_e;

  function automatic logic [1:0] flit_type(input logic [DW-1:0] flit);
    return flit[DW-1:DW-2];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, registered storage, wrap-bit pointers for full/empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Status flags; a push is refused while full even if a pop happens too
  always_comb begin
    empty_o = (wr_q == rd_q);
    full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
  end

  // Next pointers and storage contents
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    mem_d = mem_q;
    if (do_push) begin
      mem_d[wr_q[AW-1:0]] = data_i;
      wr_d = wr_q + (AW+1)'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + (AW+1)'(1);
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

  assign data_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/gather_unpacker.sv
// Receive stage: strips HEAD/TAIL, tags BODY payloads with stream_id, flags malformed packets.
module gather_unpacker #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SID_W      = gather_unpacker_pkg::SID_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                valid_i_nw,
  input  logic [gather_unpacker_pkg::DW-1:0]  data_i_nw,
  output logic                                ready_o_nw,
  output logic                                valid_o_pe,
  output logic [gather_unpacker_pkg::DW-3:0]  data_o_pe,
  output logic [SID_W-1:0]                    sid_o_pe,
  output logic                                last_o_pe,
  input  logic                                ready_i_pe,
  output logic                                err_o,
  output logic [1:0]                          err_code_o
);

  import gather_unpacker_pkg::*;

  localparam int unsigned FW = DW - 2 + SID_W + 1;
  localparam logic [PKT_LEN_LOG-1:0] NB_C    = PKT_LEN_LOG'(NB);
  localparam logic [PKT_LEN_LOG-1:0] NB_LAST = PKT_LEN_LOG'(NB - 1);

  state_e                 state_q, state_d;
  logic [PKT_LEN_LOG-1:0] cnt_q, cnt_d;
  logic [SID_W-1:0]       sid_q, sid_d;
  logic                   err_q, err_d;
  err_code_e              err_code_q, err_code_d;

  logic [1:0]    ftype;
  logic          acc;
  logic          push;
  logic          fifo_full;
  logic          fifo_empty;
  logic [FW-1:0] push_data;
  logic [FW-1:0] pop_data;

  // State, counter, latched stream_id and registered error strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WAIT_HEAD;
      cnt_q      <= '0;
      sid_q      <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_STRAY;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sid_q      <= sid_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // Next state: HEAD opens a packet, TAIL closes it
  always_comb begin
    state_d = state_q;
    if (acc) begin
      unique case (state_q)
        WAIT_HEAD: if (ftype == HEAD) state_d = IN_PKT;
        IN_PKT:    if (ftype == TAIL) state_d = WAIT_HEAD;
        default:   state_d = WAIT_HEAD;
      endcase
    end
  end

  // Handshake, push, counter/sid updates and error classification
  always_comb begin
    ftype      = flit_type(data_i_nw);
    ready_o_nw = (state_q == WAIT_HEAD) || (ftype != BODY) || !fifo_full;
    acc        = valid_i_nw && ready_o_nw;
    push       = 1'b0;
    cnt_d      = cnt_q;
    sid_d      = sid_q;
    err_d      = 1'b0;
    err_code_d = ERR_STRAY;
    push_data  = {data_i_nw[DW-3:0], sid_q, (cnt_q == NB_LAST)};
    if (acc) begin
      if (state_q == WAIT_HEAD) begin
        if (ftype == HEAD) begin
          sid_d = data_i_nw[SID_W-1:0];
          cnt_d = '0;
        end else if (ftype == BODY || ftype == TAIL) begin
          err_d      = 1'b1;
          err_code_d = ERR_STRAY;
        end
      end else begin
        unique case (ftype)
          HEAD: begin
            err_d      = 1'b1;
            err_code_d = ERR_NESTED;
            sid_d      = data_i_nw[SID_W-1:0];
            cnt_d      = '0;
          end
          BODY: begin
            if (cnt_q < NB_C) begin
              push  = 1'b1;
              cnt_d = cnt_q + PKT_LEN_LOG'(1);
            end else begin
              err_d      = 1'b1;
              err_code_d = ERR_LONG;
            end
          end
          TAIL: begin
            if (cnt_q != NB_C) begin
              err_d      = 1'b1;
              err_code_d = ERR_SHORT;
            end
          end
          default: ;
        endcase
      end
    end
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (ready_i_pe),
    .data_o  (pop_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign valid_o_pe = !fifo_empty;
  assign data_o_pe  = pop_data[FW-1:SID_W+1];
  assign sid_o_pe   = pop_data[SID_W:1];
  assign last_o_pe  = pop_data[0];
  assign err_o      = err_q;
  assign err_code_o = err_code_q;

endmodule

// File: tb/tb_gather_unpacker.sv
// Directed bench for gather_unpacker with an expected-payload scoreboard.
module tb_gather_unpacker;
  import gather_unpacker_pkg::*;

  localparam int unsigned PW = DW - 2;

  typedef struct packed {
    logic [PW-1:0]    data;
    logic [SID_W-1:0] sid;
    logic             last;
  } out_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid_i_nw;
  logic [DW-1:0]    data_i_nw;
  logic             ready_o_nw;
  logic             valid_o_pe;
  logic [PW-1:0]    data_o_pe;
  logic [SID_W-1:0] sid_o_pe;
  logic             last_o_pe;
  logic             ready_i_pe;
  logic             err_o;
  logic [1:0]       err_code_o;

  int          n_cmp = 0;
  int          n_bad = 0;
  out_t        exp_q[$];
  int unsigned last_waits;

  always #5 clk = ~clk;

  gather_unpacker #(
    .FIFO_DEPTH (4),
    .SID_W      (SID_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i_nw (valid_i_nw),
    .data_i_nw  (data_i_nw),
    .ready_o_nw (ready_o_nw),
    .valid_o_pe (valid_o_pe),
    .data_o_pe  (data_o_pe),
    .sid_o_pe   (sid_o_pe),
    .last_o_pe  (last_o_pe),
    .ready_i_pe (ready_i_pe),
    .err_o      (err_o),
    .err_code_o (err_code_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every PE handshake must match the oldest expected payload
  always @(negedge clk) begin
    if (!rst && valid_o_pe && ready_i_pe) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid_o_pe", 64'(valid_o_pe), 64'd0);
      end else begin
        out_t want;
        want = exp_q.pop_front();
        chk("pe_output", 64'({data_o_pe, sid_o_pe, last_o_pe}), 64'(want));
      end
    end
  end

  // Drive one flit right after a posedge, wait (bounded) for acceptance, check the error strobe
  task automatic send(input logic [1:0] t, input logic [PW-1:0] pl, input bit exp_push,
                      input logic [SID_W-1:0] exp_sid, input bit exp_last,
                      input bit exp_err, input logic [1:0] exp_code);
    int unsigned waits = 0;
    valid_i_nw = 1'b1;
    data_i_nw  = {t, pl};
    while (!ready_o_nw && waits < 200) begin
      @(posedge clk); #1;
      waits++;
    end
    last_waits = waits;
    chk("ready_o_nw_accept", 64'(ready_o_nw), 64'd1);
    if (exp_push) exp_q.push_back('{data: pl, sid: exp_sid, last: exp_last});
    @(posedge clk); #1;
    valid_i_nw = 1'b0;
    data_i_nw  = '0;
    chk("err_o", 64'(err_o), 64'(exp_err));
    if (exp_err) chk("err_code_o", 64'(err_code_o), 64'(exp_code));
  endtask

  task automatic head(input logic [SID_W-1:0] s, input bit e = 1'b0, input logic [1:0] c = 2'd0);
    send(HEAD, PW'(s), 1'b0, '0, 1'b0, e, c);
  endtask

  task automatic body(input logic [PW-1:0] pl, input logic [SID_W-1:0] s, input bit l);
    send(BODY, pl, 1'b1, s, l, 1'b0, 2'd0);
  endtask

  task automatic body_err(input logic [PW-1:0] pl, input logic [1:0] c);
    send(BODY, pl, 1'b0, '0, 1'b0, 1'b1, c);
  endtask

  task automatic tail(input bit e = 1'b0, input logic [1:0] c = 2'd0);
    send(TAIL, '0, 1'b0, '0, 1'b0, e, c);
  endtask

  task automatic drain();
    int unsigned w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    chk("drain_remaining", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst        = 1'b1;
    valid_i_nw = 1'b0;
    data_i_nw  = '0;
    ready_i_pe = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_valid_o_pe", 64'(valid_o_pe), 64'd0);
    chk("rst_err_o",      64'(err_o),      64'd0);
    chk("rst_err_code_o", 64'(err_code_o), 64'd0);
    chk("rst_data_o_pe",  64'(data_o_pe),  64'd0);
    chk("rst_sid_o_pe",   64'(sid_o_pe),   64'd0);
    chk("rst_last_o_pe",  64'(last_o_pe),  64'd0);

    // Nominal packet, PE always ready
    head(10'h2A5);
    chk("valid_before_body", 64'(valid_o_pe), 64'd0);
    body(PW'(1), 10'h2A5, 1'b0);
    chk("first_valid_latency", 64'(valid_o_pe), 64'd1);
    for (int i = 2; i <= 6; i++) body(PW'(i), 10'h2A5, i == 6);
    tail();
    drain();

    // Backpressure: PE stalled for 10 cycles, fifo fills at 4
    ready_i_pe = 1'b0;
    head(10'h2A5);
    for (int i = 1; i <= 4; i++) body(PW'(i), 10'h2A5, 1'b0);
    valid_i_nw = 1'b1;
    data_i_nw  = {BODY, PW'(5)};
    for (int c = 0; c < 5; c++) begin
      chk("ready_o_nw_full",   64'(ready_o_nw), 64'd0);
      chk("stall_valid_o_pe",  64'(valid_o_pe), 64'd1);
      chk("stall_data_o_pe",   64'(data_o_pe),  64'd1);
      chk("stall_sid_o_pe",    64'(sid_o_pe),   64'h2A5);
      chk("stall_last_o_pe",   64'(last_o_pe),  64'd0);
      @(posedge clk); #1;
    end
    ready_i_pe = 1'b1;
    body(PW'(5), 10'h2A5, 1'b0);
    body(PW'(6), 10'h2A5, 1'b1);
    tail();
    drain();

    // Stray body, then short packet
    body_err(PW'(99), ERR_STRAY);
    head(10'd3);
    body(PW'(11), 10'd3, 1'b0);
    body(PW'(12), 10'd3, 1'b0);
    tail(1'b1, ERR_SHORT);
    body_err(PW'(98), ERR_STRAY);
    drain();

    // Long packet: seventh body dropped
    head(10'd1);
    for (int i = 1; i <= 6; i++) body(PW'(i), 10'd1, i == 6);
    body_err(PW'(7), ERR_LONG);
    tail();
    drain();

    // Nested head retags only later bodies
    head(10'd1);
    body(PW'(21), 10'd1, 1'b0);
    body(PW'(22), 10'd1, 1'b0);
    head(10'd9, 1'b1, ERR_NESTED);
    for (int i = 1; i <= 6; i++) body(PW'(30 + i), 10'd9, i == 6);
    tail();
    drain();

    // Back-to-back packets, no stalls expected on the network side
    head(10'd5);
    for (int i = 1; i <= 6; i++) begin
      body(PW'(40 + i), 10'd5, i == 6);
      chk("b2b_no_stall", 64'(last_waits), 64'd0);
    end
    tail();
    head(10'd6);
    for (int i = 1; i <= 6; i++) begin
      body(PW'(50 + i), 10'd6, i == 6);
      chk("b2b_no_stall", 64'(last_waits), 64'd0);
    end
    tail();
    drain();

    // Reset in the middle of a packet with payloads buffered
    ready_i_pe = 1'b0;
    head(10'h077);
    body(PW'(61), 10'h077, 1'b0);
    body(PW'(62), 10'h077, 1'b0);
    body(PW'(63), 10'h077, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    ready_i_pe = 1'b1;
    chk("post_rst_valid_o_pe", 64'(valid_o_pe), 64'd0);
    chk("post_rst_err_o",      64'(err_o),      64'd0);
    body_err(PW'(64), ERR_STRAY);
    head(10'h100);
    for (int i = 1; i <= 6; i++) body(PW'(70 + i), 10'h100, i == 6);
    tail();
    drain();

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
